// File: rtl/tempest_rom_loader_pkg.sv
// Shared types and sizes for the Tempest ROM loader.
// Region tags, FSM states and the write record carried through the pipe.
package tempest_loader_pkg;

    localparam int PROG_SIZE_DEF = 20480;
    localparam int VEC_SIZE_DEF  = 4096;
    localparam int IMAGE_SIZE    = PROG_SIZE_DEF + VEC_SIZE_DEF;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_PROG,
        REG_VEC
    } region_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef struct packed {
        region_t     region;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

endpackage

// File: rtl/tempest_rom_loader_if.sv
// ioctl download stream plus ROM write port between hps_io and the loader.
// master = HPS/RAM side, slave = loader.
interface tempest_rom_loader_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        rom_ready;
    logic        prog_we;
    logic [14:0] prog_addr;
    logic        vec_we;
    logic [11:0] vec_addr;
    logic [7:0]  rom_data;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
        input  ioctl_wait, prog_we, prog_addr, vec_we, vec_addr, rom_data
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rom_ready,
        output ioctl_wait, prog_we, prog_addr, vec_we, vec_addr, rom_data
    );

endinterface

// File: rtl/tempest_rom_loader_skid_buf.sv
// Output register with one skid entry; the skid catches a byte that
// arrives while the presented write waits for rom_ready.
module loader_skid_buf
    import tempest_loader_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  wr_t  in_data,
    output logic in_ready,
    output logic out_valid,
    output wr_t  out_data,
    input  logic out_ready
);

    logic skid_valid;
    wr_t  skid_data;
    logic out_free;

    assign in_ready = !skid_valid;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/tempest_rom_loader.sv
// Decodes the HPS ioctl stream into program/vector ROM writes and
// holds the core in reset until a complete, clean image has landed.
module tempest_rom_loader
    import tempest_loader_pkg::*;
#(
    parameter int PROG_SIZE    = PROG_SIZE_DEF,
    parameter int VEC_SIZE     = VEC_SIZE_DEF,
    parameter bit REQUIRE_LOAD = 1'b1
) (
    input  logic                 clk_25,
    input  logic                 RESET_n,
    tempest_rom_loader_if.slave  bus,
    output logic                 load_done,
    output logic                 load_err,
    output logic [15:0]          checksum,
    output logic                 core_reset_n
);

    localparam int IMG = PROG_SIZE + VEC_SIZE;

    state_t      state, state_nx;
    logic        dl_q;
    logic [24:0] count;
    logic        rise, clear, finish, empty;
    logic        strobe, take, bad;
    logic        in_ready, out_valid;
    wr_t         in_w, out_w;

    assign rise   = bus.ioctl_download && !dl_q;
    assign strobe = (state == S_LOAD) && bus.ioctl_download && bus.ioctl_wr;
    assign take   = strobe && in_ready && (in_w.region != REG_NONE);
    assign bad    = strobe && (!in_ready || in_w.region == REG_NONE);
    assign empty  = !out_valid && in_ready;

    always_comb begin
        in_w      = '0;
        in_w.data = bus.ioctl_dout;
        if (bus.ioctl_addr < 25'(PROG_SIZE)) begin
            in_w.region = REG_PROG;
            in_w.addr   = bus.ioctl_addr[14:0];
        end else if (bus.ioctl_addr < 25'(IMG)) begin
            in_w.region = REG_VEC;
            in_w.addr   = 15'(bus.ioctl_addr - 25'(PROG_SIZE));
        end
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        finish   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (rise) begin
                    state_nx = S_LOAD;
                    clear    = 1'b1;
                end
            end
            S_LOAD: begin
                if (!bus.ioctl_download) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                // a new download that rose mid-flush starts once the pipe drains
                if (empty) begin
                    finish   = 1'b1;
                    clear    = bus.ioctl_download;
                    state_nx = bus.ioctl_download ? S_LOAD : S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // dl_q resets high so a download already in progress is not mistaken for a rise
    always_ff @(posedge clk_25 or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= S_IDLE;
            dl_q         <= 1'b1;
            count        <= '0;
            checksum     <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            core_reset_n <= 1'b0;
        end else begin
            state        <= state_nx;
            dl_q         <= bus.ioctl_download;
            core_reset_n <= REQUIRE_LOAD ? load_done : 1'b1;
            if (clear) begin
                count     <= '0;
                checksum  <= '0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else begin
                if (take) begin
                    count    <= count + 25'd1;
                    checksum <= checksum + {8'h00, in_w.data};
                end
                if (bad) load_err <= 1'b1;
                if (finish) begin
                    load_done <= !load_err && (count == 25'(IMG));
                    if (load_err || count != 25'(IMG)) load_err <= 1'b1;
                end
            end
        end
    end

    loader_skid_buf u_skid (
        .clk       (clk_25),
        .rst_n     (RESET_n),
        .in_valid  (take),
        .in_data   (in_w),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_w),
        .out_ready (bus.rom_ready)
    );

    assign bus.ioctl_wait = !in_ready;
    assign bus.prog_we    = out_valid && (out_w.region == REG_PROG);
    assign bus.vec_we     = out_valid && (out_w.region == REG_VEC);
    assign bus.prog_addr  = out_w.addr;
    assign bus.vec_addr   = out_w.addr[11:0];
    assign bus.rom_data   = out_w.data;

endmodule
